// File: rtl/wb_rd_arbiter.sv
// Two-to-one Wishbone read arbiter sharing one wb2axi_read bridge between ibus and dbus.
// Latency: request sampled at edge N drives wb_cyc after edge N; bridge ack returns to owner combinationally.
// Backpressure: requesters hold cyc until ack; RELEASE forces one idle wb_cyc cycle between transactions.
// Optional watchdog enabled by defining WB_RD_ARB_TIMEOUT_EN (timeout_err tied low otherwise).
module wb_rd_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] ibus_adr,
  input  logic                  ibus_cyc,
  output logic [DATA_WIDTH-1:0] ibus_rdt,
  output logic                  ibus_ack,
  input  logic [ADDR_WIDTH-1:0] dbus_adr,
  input  logic                  dbus_cyc,
  output logic [DATA_WIDTH-1:0] dbus_rdt,
  output logic                  dbus_ack,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic                  wb_cyc,
  input  logic [DATA_WIDTH-1:0] wb_rdt,
  input  logic                  wb_ack,
  output logic [1:0]            grant,
  output logic                  timeout_err
);

  // Out-of-range parameters are rejected at elaboration.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("wb_rd_arbiter: STARVE_LIMIT or TIMEOUT_CYCLES out of range");
  end

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT_I   = 3'd1,
    GNT_D   = 3'd2,
    DRAIN   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] adr_nxt;
  logic                  cyc_nxt;
  logic [1:0]            grant_nxt;
  logic [3:0]            starve_cnt, starve_nxt;
  logic                  tmo_hit;
  logic                  pick_i, pick_d;

`ifdef WB_RD_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  // The limit is hit in the cycle whose count equals TIMEOUT_CYCLES-1, i.e. the TIMEOUT_CYCLES-th grant cycle.
  assign tmo_hit = ((state == GNT_I) || (state == GNT_D)) && (tmo_cnt == TMO_LAST);

  // Watchdog counter: zero outside a grant, counts grant cycles without a bridge ack; sticky error flag.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == GNT_I) || (state == GNT_D)) begin
        if (!wb_ack) tmo_cnt <= tmo_cnt + 16'd1;
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_hit && !wb_ack) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration winner: dbus first unless ibus has been starved STARVE_LIMIT times.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (dbus_cyc && (starve_cnt < LIMIT)) pick_d = 1'b1;
    else if (ibus_cyc)                    pick_i = 1'b1;
    else if (dbus_cyc)                    pick_d = 1'b1;
  end

  // Next-state, registered-output next values and combinational ack/data routing.
  always_comb begin
    state_nxt  = state;
    adr_nxt    = wb_adr;
    cyc_nxt    = wb_cyc;
    grant_nxt  = grant;
    starve_nxt = starve_cnt;
    ibus_ack   = 1'b0;
    dbus_ack   = 1'b0;
    ibus_rdt   = '0;
    dbus_rdt   = '0;
    case (state)
      IDLE, RELEASE: begin
        state_nxt = IDLE;
        cyc_nxt   = 1'b0;
        grant_nxt = 2'b00;
        if (pick_d) begin
          state_nxt = GNT_D;
          adr_nxt   = dbus_adr;
          cyc_nxt   = 1'b1;
          grant_nxt = 2'b10;
        end else if (pick_i) begin
          state_nxt = GNT_I;
          adr_nxt   = ibus_adr;
          cyc_nxt   = 1'b1;
          grant_nxt = 2'b01;
        end
        if (!ibus_cyc || pick_i)            starve_nxt = '0;
        else if (pick_d && starve_cnt < LIMIT) starve_nxt = starve_cnt + 4'd1;
      end
      GNT_I: begin
        if (wb_ack) begin
          // An owner that dropped cyc mid-grant gets no ack; the data is discarded.
          ibus_ack  = grant[0] & ibus_cyc;
          ibus_rdt  = ibus_ack ? wb_rdt : '0;
          state_nxt = RELEASE;
          cyc_nxt   = 1'b0;
          grant_nxt = 2'b00;
        end else if (tmo_hit) begin
          ibus_ack  = grant[0] & ibus_cyc;
          state_nxt = DRAIN;
          grant_nxt = 2'b00;
        end
      end
      GNT_D: begin
        if (wb_ack) begin
          dbus_ack  = grant[1] & dbus_cyc;
          dbus_rdt  = dbus_ack ? wb_rdt : '0;
          state_nxt = RELEASE;
          cyc_nxt   = 1'b0;
          grant_nxt = 2'b00;
        end else if (tmo_hit) begin
          dbus_ack  = grant[1] & dbus_cyc;
          state_nxt = DRAIN;
          grant_nxt = 2'b00;
        end
      end
      DRAIN: begin
        // Keep the bridge cycle open until its late response arrives, then drop it.
        if (wb_ack) begin
          state_nxt = RELEASE;
          cyc_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = 1'b0;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // State and registered bridge-side outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      wb_adr     <= '0;
      wb_cyc     <= 1'b0;
      grant      <= 2'b00;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      wb_adr     <= adr_nxt;
      wb_cyc     <= cyc_nxt;
      grant      <= grant_nxt;
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rd_arbiter.sv
// Directed bench for wb_rd_arbiter with an expected-grant scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Scoreboard entries (owner, address) are pushed when requests are raised and popped per bridge cycle.
module tb_wb_rd_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] ibus_adr, dbus_adr, wb_adr, wb_rdt, ibus_rdt, dbus_rdt;
  logic        ibus_cyc, dbus_cyc, ibus_ack, dbus_ack, wb_cyc, wb_ack, timeout_err;
  logic [1:0]  grant;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  gnt;
    logic [31:0] adr;
  } exp_t;
  exp_t exp_q[$];

  wb_rd_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ibus_adr(ibus_adr), .ibus_cyc(ibus_cyc), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
    .dbus_adr(dbus_adr), .dbus_cyc(dbus_cyc), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
    .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_rdt(wb_rdt), .wb_ack(wb_ack),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Serve one bridge transaction: the grant must appear within one edge, ack after lat cycles.
  task automatic serve(input int lat, input logic [31:0] dat, input bit keep, input logic [31:0] nadr);
    exp_t e;
    bit   own_i;
    if (!wb_cyc) tick();
    chk("gnt_latency", {31'd0, wb_cyc}, 32'd1);
    if (exp_q.size() == 0) begin
      chk("sb_underflow", {30'd0, grant}, 32'd0);
      return;
    end
    e     = exp_q.pop_front();
    own_i = (e.gnt == 2'b01);
    wb_rdt = 32'hA5A5A5A5;
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) tick();
      if (i == lat) begin
        wb_ack = 1'b1;
        wb_rdt = dat;
      end
      @(negedge ACLK);
      chk("grant", {30'd0, grant}, {30'd0, e.gnt});
      chk("wb_adr", wb_adr, e.adr);
      if (i < lat) begin
        chk("early_ack", {30'd0, ibus_ack, dbus_ack}, 32'd0);
        chk("rdt_leak", ibus_rdt | dbus_rdt, 32'd0);
      end
    end
    chk("owner_ack", {30'd0, ibus_ack, dbus_ack}, own_i ? 32'd2 : 32'd1);
    chk("owner_rdt", own_i ? ibus_rdt : dbus_rdt, dat);
    chk("other_rdt", own_i ? dbus_rdt : ibus_rdt, 32'd0);
    tick();
    wb_ack = 1'b0;
    wb_rdt = 32'h0;
    if (own_i) begin
      if (keep) ibus_adr = nadr; else ibus_cyc = 1'b0;
    end else begin
      if (keep) dbus_adr = nadr; else dbus_cyc = 1'b0;
    end
    @(negedge ACLK);
    chk("release_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("release_gnt", {30'd0, grant}, 32'd0);
  endtask

  initial begin
    ARESETN  = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_cyc = 1'b0;
    wb_rdt   = '0; wb_ack   = 1'b0;

    // Reset values
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_wb_adr", wb_adr, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    chk("rst_rdts", ibus_rdt | dbus_rdt, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    tick();
    ARESETN = 1'b1;
    tick();

    // ibus only, bridge latency 3
    ibus_adr = 32'h00000004; ibus_cyc = 1'b1;
    exp_q.push_back('{2'b01, 32'h00000004});
    serve(3, 32'h002081B3, 1'b0, 32'h0);

    // Simultaneous requests: dbus first, one RELEASE cycle, then ibus
    ibus_adr = 32'h00000000; ibus_cyc = 1'b1;
    dbus_adr = 32'h00006000; dbus_cyc = 1'b1;
    exp_q.push_back('{2'b10, 32'h00006000});
    exp_q.push_back('{2'b01, 32'h00000000});
    serve(2, 32'h11112222, 1'b0, 32'h0);
    serve(2, 32'h33334444, 1'b0, 32'h0);

    // Starvation: four dbus grants, then ibus, then dbus resumes
    ibus_adr = 32'h00000100; ibus_cyc = 1'b1;
    dbus_adr = 32'h00008000; dbus_cyc = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back('{2'b10, 32'h00008000 + 32'(4 * k)});
    exp_q.push_back('{2'b01, 32'h00000100});
    exp_q.push_back('{2'b10, 32'h00008010});
    for (int k = 0; k < 4; k++) serve(1, 32'hD0000000 + 32'(k), 1'b1, 32'h00008004 + 32'(4 * k));
    serve(2, 32'h1CEB00DA, 1'b0, 32'h0);
    serve(1, 32'hD0000004, 1'b0, 32'h0);

    // Address stability: ibus_adr changes mid-grant, wb_adr holds
    ibus_adr = 32'h00000010; ibus_cyc = 1'b1;
    exp_q.push_back('{2'b01, 32'h00000010});
    tick();
    @(negedge ACLK);
    chk("stable_adr_pre", wb_adr, 32'h00000010);
    ibus_adr = 32'h00000020;
    serve(3, 32'hCAFEF00D, 1'b0, 32'h0);

`ifdef WB_RD_ARB_TIMEOUT_EN
    // Watchdog: no bridge ack, owner acked with zero data in grant cycle 16, late ack swallowed
    ibus_adr = 32'h00000040; ibus_cyc = 1'b1;
    wb_rdt   = 32'hA5A5A5A5;
    tick();
    @(negedge ACLK);
    chk("wd_grant", {30'd0, grant}, 32'd1);
    chk("wd_adr", wb_adr, 32'h00000040);
    for (int i = 1; i < 16; i++) begin
      chk("wd_early_ack", {31'd0, ibus_ack}, 32'd0);
      tick();
      @(negedge ACLK);
    end
    chk("wd_ack", {31'd0, ibus_ack}, 32'd1);
    chk("wd_rdt", ibus_rdt, 32'd0);
    tick();
    ibus_cyc = 1'b0;
    @(negedge ACLK);
    chk("wd_err", {31'd0, timeout_err}, 32'd1);
    chk("drain_cyc", {31'd0, wb_cyc}, 32'd1);
    chk("drain_gnt", {30'd0, grant}, 32'd0);
    wb_ack = 1'b1;
    wb_rdt = 32'hDEADBEEF;
    #1;
    chk("drain_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    chk("drain_rdt", ibus_rdt | dbus_rdt, 32'd0);
    tick();
    wb_ack = 1'b0;
    wb_rdt = 32'h0;
    @(negedge ACLK);
    chk("drain_release", {31'd0, wb_cyc}, 32'd0);
`else
    // Without the watchdog a slow bridge is simply waited for
    ibus_adr = 32'h00000040; ibus_cyc = 1'b1;
    exp_q.push_back('{2'b01, 32'h00000040});
    serve(20, 32'h0BADC0DE, 1'b0, 32'h0);
    chk("no_tmo_err", {31'd0, timeout_err}, 32'd0);
`endif

    // Reset mid-grant, then a pending ibus request is granted normally
    dbus_adr = 32'h00000200; dbus_cyc = 1'b1;
    tick();
    @(negedge ACLK);
    chk("pre_rst_grant", {30'd0, grant}, 32'd2);
    ibus_adr = 32'h00000300; ibus_cyc = 1'b1;
    ARESETN  = 1'b0;
    #1;
    chk("rst_async_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_async_gnt", {30'd0, grant}, 32'd0);
    wb_ack = 1'b1;
    wb_rdt = 32'hDEADBEEF;
    #1;
    chk("rst_ack_ignored", {30'd0, ibus_ack, dbus_ack}, 32'd0);
    tick();
    wb_ack   = 1'b0;
    wb_rdt   = 32'h0;
    dbus_cyc = 1'b0;
    ARESETN  = 1'b1;
    exp_q.push_back('{2'b01, 32'h00000300});
    serve(2, 32'h600DF00D, 1'b0, 32'h0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Global guard so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "bench watchdog expired");
  end

endmodule
